// File: rtl/param_datapath_pkg.sv
// rtl/param_datapath_pkg.sv - shared encodings for the single-bus datapath
package param_datapath_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_SHL  = 3'd4,
    OP_SHR  = 3'd5,
    OP_NOT  = 3'd6,
    OP_LOAD = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_T_Y   = 3'd1,
    S_T_Z   = 3'd2,
    S_T_MAR = 3'd3,
    S_T_RD  = 3'd4,
    S_T_WB  = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    SRC_ZERO = 3'd0,
    SRC_RB   = 3'd1,
    SRC_RC   = 3'd2,
    SRC_ZLO  = 3'd3,
    SRC_MDR  = 3'd4
  } bus_src_e;

endpackage

// File: rtl/param_datapath_if.sv
// rtl/param_datapath_if.sv - instruction request and memory read signals of the datapath
interface param_datapath_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
);
  localparam int SEL_W = $clog2(NUM_REGS);

  logic              start;
  logic [2:0]        op;
  logic [SEL_W-1:0]  ra;
  logic [SEL_W-1:0]  rb;
  logic [SEL_W-1:0]  rc;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic              zero;
  logic [DATA_W-1:0] bus_out;

  // Requester side: issues instructions and answers memory reads.
  modport master (
    output start, op, ra, rb, rc, mem_ack, mem_rdata,
    input  mem_addr, mem_rd, busy, done, zero, bus_out
  );

  // Datapath side.
  modport slave (
    input  start, op, ra, rb, rc, mem_ack, mem_rdata,
    output mem_addr, mem_rd, busy, done, zero, bus_out
  );
endinterface

// File: rtl/param_datapath_alu.sv
// rtl/param_datapath_alu.sv - combinational ALU param_alu used in the T_Z step
module param_alu
  import param_datapath_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);
  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] sh;
  assign sh = b[SH_W-1:0];

  // Result of Y op bus; shifts use only the low bits of the second operand.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_SHL:  result = a << sh;
      OP_SHR:  result = a >> sh;
      OP_NOT:  result = ~a;
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/param_datapath.sv
// rtl/param_datapath.sv - single-bus register datapath; PARAM_DATAPATH_R0_ZERO_EN makes R0 a hardwired zero
module param_datapath
  import param_datapath_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input logic         clk,
  input logic         rst_n,
  param_datapath_if.slave dp
);
  localparam int SEL_W = $clog2(NUM_REGS);

  state_e            state_q, state_d;
  bus_src_e          bus_src;
  op_e               op_q;
  logic [SEL_W-1:0]  ra_q, rb_q, rc_q;
  logic [DATA_W-1:0] y_q, z_q, mar_q, mdr_q;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] bus, alu_res, rb_val, rc_val;
  logic              setup_q, done_q, zero_q, mem_rd, wr_en;

  param_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .a      (y_q),
    .b      (bus),
    .result (alu_res)
  );

  // Source register reads, with R0 optionally forced to zero.
  always_comb begin
    rb_val = regs[rb_q];
    rc_val = regs[rc_q];
    wr_en  = 1'b1;
`ifdef PARAM_DATAPATH_R0_ZERO_EN
    if (rb_q == '0) rb_val = '0;
    if (rc_q == '0) rc_val = '0;
    wr_en = (ra_q != '0);
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and bus source; LOAD spends a second T_MAR cycle so the
  // address is stable on mem_addr for a full cycle before the read request.
  always_comb begin
    state_d = state_q;
    bus_src = SRC_ZERO;
    mem_rd  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dp.start) state_d = (op_e'(dp.op) == OP_LOAD) ? S_T_MAR : S_T_Y;
      end
      S_T_Y: begin
        bus_src = SRC_RB;
        state_d = S_T_Z;
      end
      S_T_Z: begin
        bus_src = SRC_RC;
        state_d = S_T_WB;
      end
      S_T_MAR: begin
        if (!setup_q) bus_src = SRC_RB;
        else          state_d = S_T_RD;
      end
      S_T_RD: begin
        mem_rd = 1'b1;
        if (dp.mem_ack) state_d = S_T_WB;
      end
      S_T_WB: begin
        bus_src = (op_q == OP_LOAD) ? SRC_MDR : SRC_ZLO;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Single internal bus multiplexer.
  always_comb begin
    bus = '0;
    case (bus_src)
      SRC_RB:  bus = rb_val;
      SRC_RC:  bus = rc_val;
      SRC_ZLO: bus = z_q;
      SRC_MDR: bus = mdr_q;
      default: bus = '0;
    endcase
  end

  // Instruction capture and internal Y/Z/MAR/MDR registers, done and zero flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_ADD;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      y_q     <= '0;
      z_q     <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      setup_q <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE && dp.start) begin
        op_q <= op_e'(dp.op);
        ra_q <= dp.ra;
        rb_q <= dp.rb;
        rc_q <= dp.rc;
      end
      setup_q <= (state_q == S_T_MAR) && !setup_q;
      if (state_q == S_T_Y) y_q <= bus;
      if (state_q == S_T_Z) z_q <= alu_res;
      if (state_q == S_T_MAR && !setup_q) mar_q <= bus;
      if (state_q == S_T_RD && dp.mem_ack) mdr_q <= dp.mem_rdata;
      done_q <= (state_q == S_T_WB);
      if (state_q == S_T_WB) zero_q <= !wr_en || (bus == '0);
    end
  end

  // General-purpose register file, written from the bus in T_WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (state_q == S_T_WB && wr_en) begin
      regs[ra_q] <= bus;
    end
  end

  assign dp.mem_addr = mar_q;
  assign dp.mem_rd   = mem_rd;
  assign dp.busy     = (state_q != S_IDLE);
  assign dp.done     = done_q;
  assign dp.zero     = zero_q;
  assign dp.bus_out  = bus;
endmodule

// File: tb/tb_param_datapath.sv
// tb/tb_param_datapath.sv - self-checking bench for param_datapath against an instruction-level model
module tb_param_datapath;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int SEL_W    = $clog2(NUM_REGS);
  localparam logic [DATA_W-1:0] SH_M = DATA_W'(1) << $clog2(DATA_W);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  param_datapath_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dp ();

  param_datapath #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dp    (dp)
  );

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] ref_r [NUM_REGS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rd_reg(input int k);
`ifdef PARAM_DATAPATH_R0_ZERO_EN
    if (k == 0) return '0;
`endif
    return ref_r[k];
  endfunction

  function automatic logic [DATA_W-1:0] ref_alu(input int op, input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] sh;
    sh = b % SH_M;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a << sh;
      5: return a >> sh;
      6: return ~a;
      default: return '0;
    endcase
  endfunction

  function automatic logic exp_zero_of(input int ra, input logic [DATA_W-1:0] v);
`ifdef PARAM_DATAPATH_R0_ZERO_EN
    if (ra == 0) return 1'b1;
`endif
    return (v == '0);
  endfunction

  // Issues one instruction in the current cycle (called at a negedge) and
  // returns at the negedge of the cycle where done is high.
  task automatic run(input int op, input int ra, input int rb, input int rc,
                     input int waits, input logic [DATA_W-1:0] rdata, input bit poke);
    logic [DATA_W-1:0] a, b, exp_res, prev_bus;
    int n, rd_cnt, lat;
    bit seen;
    a        = rd_reg(rb);
    b        = rd_reg(rc);
    exp_res  = (op == 7) ? rdata : ref_alu(op, a, b);
    lat      = (op == 7) ? 5 + waits : 4;
    chk("idle_before_start", dp.busy, 0);
    dp.start = 1'b1;
    dp.op    = 3'(op);
    dp.ra    = SEL_W'(ra);
    dp.rb    = SEL_W'(rb);
    dp.rc    = SEL_W'(rc);
    @(negedge clk);
    dp.start = 1'b0;
    dp.op    = 3'($urandom);
    dp.ra    = SEL_W'($urandom);
    dp.rb    = SEL_W'($urandom);
    dp.rc    = SEL_W'($urandom);
    n = 1; rd_cnt = 0; seen = 1'b0; prev_bus = '0;
    while (n <= 40) begin
      dp.mem_ack   = 1'b0;
      dp.mem_rdata = DATA_W'($urandom);
      if (dp.done) begin
        seen = 1'b1;
        break;
      end
      if (n == 1) chk("first_src", dp.bus_out, a);
      if (n == 2 && op != 7) chk("second_src", dp.bus_out, b);
      if (dp.mem_rd) begin
        rd_cnt++;
        chk("mem_addr", dp.mem_addr, a);
        if (rd_cnt > waits) begin
          dp.mem_ack   = 1'b1;
          dp.mem_rdata = rdata;
        end
      end else begin
        dp.mem_ack = 1'($urandom);
      end
      if (poke) dp.start = (n == 2);
      prev_bus = dp.bus_out;
      @(negedge clk);
      n++;
    end
    dp.start = 1'b0;
    chk("done_seen", seen, 1);
    chk("latency", n, lat);
    chk("wb_value", prev_bus, exp_res);
    chk("rd_cycles", rd_cnt, (op == 7) ? waits + 1 : 0);
    chk("zero", dp.zero, exp_zero_of(ra, exp_res));
    chk("busy_at_done", dp.busy, 0);
    ref_r[ra] = exp_res;
  endtask

  task automatic load(input int ra, input logic [DATA_W-1:0] v);
    run(7, ra, 0, 0, 0, v, 1'b0);
  endtask

  initial begin
    dp.start = 1'b0; dp.op = '0; dp.ra = '0; dp.rb = '0; dp.rc = '0;
    dp.mem_ack = 1'b0; dp.mem_rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) ref_r[i] = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", dp.busy, 0);
    chk("rst_done", dp.done, 0);
    chk("rst_mem_rd", dp.mem_rd, 0);
    chk("rst_zero", dp.zero, 0);
    chk("rst_bus", dp.bus_out, 0);
    chk("rst_mem_addr", dp.mem_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD: 5 + 7 into R3
    load(1, 5); load(2, 7);
    run(0, 3, 1, 2, 0, '0, 1'b0);
    chk("add_r3_const", ref_r[3], DATA_W'(12));
    run(3, 11, 3, 3, 0, '0, 1'b0);

    // SUB wrap-around, then a zero result
    load(1, 3); load(2, 5);
    run(1, 4, 1, 2, 0, '0, 1'b0);
    load(1, 9); load(2, 9);
    run(1, 4, 1, 2, 0, '0, 1'b0);

    // LOAD through R5 with three wait cycles
    load(5, 'h100);
    run(7, 6, 5, 0, 3, DATA_W'('hDEADBEEF), 1'b0);
    run(3, 12, 6, 6, 0, '0, 1'b0);

    // SHL uses only the low shift-amount bits
    load(1, 1); load(2, 33);
    run(4, 8, 1, 2, 0, '0, 1'b0);
    run(5, 13, 2, 1, 0, '0, 1'b0);

    // start while busy is ignored
    run(0, 10, 1, 2, 0, '0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("no_extra_done", dp.done, 0);
      chk("stay_idle", dp.busy, 0);
    end

    // write to R0 then read it back onto the bus
    run(0, 0, 1, 2, 0, '0, 1'b0);
    run(3, 9, 0, 0, 0, '0, 1'b0);

    // randomized instruction mix
    for (int i = 0; i < 24; i++) begin
      run(int'($urandom_range(0, 7)), int'($urandom_range(0, NUM_REGS - 1)),
          int'($urandom_range(0, NUM_REGS - 1)), int'($urandom_range(0, NUM_REGS - 1)),
          int'($urandom_range(0, 3)), DATA_W'($urandom), 1'b0);
    end

    // Clear while the read is outstanding
    dp.start = 1'b1; dp.op = 3'd7; dp.ra = SEL_W'(7); dp.rb = SEL_W'(5); dp.rc = '0;
    dp.mem_ack = 1'b0;
    @(negedge clk);
    dp.start = 1'b0;
    for (int k = 0; k < 10 && !dp.mem_rd; k++) @(negedge clk);
    chk("reach_t_rd", dp.mem_rd, 1);
    rst_n = 1'b0;
    #1;
    chk("clr_mem_rd", dp.mem_rd, 0);
    chk("clr_busy", dp.busy, 0);
    chk("clr_bus", dp.bus_out, 0);
    chk("clr_mem_addr", dp.mem_addr, 0);
    chk("clr_zero", dp.zero, 0);
    for (int i = 0; i < NUM_REGS; i++) ref_r[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("clr_done", dp.done, 0);
    run(3, 7, 7, 7, 0, '0, 1'b0);
    run(0, 14, 5, 6, 0, '0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/param_datapath.md
PARAM_DATAPATH -- requirements
Module: param_datapath

Interface
- REQ-001: Parameter DATA_W, default 32, data, bus, register and memory word width (>= 8).
- REQ-002: Parameter NUM_REGS, default 16, general-purpose register count (power of two, >= 2); derived constant SEL_W = clog2(NUM_REGS).
- REQ-003: Clock  in  1  single clock; all state updates on rising edge.
- REQ-004: Clear  in  1  reset, asynchronous, active-low.
- REQ-005: start  in  1  request to run one instruction; sampled only in IDLE.
- REQ-006: op  in  3  0=ADD, 1=SUB, 2=AND, 3=OR, 4=SHL, 5=SHR (logical), 6=NOT, 7=LOAD.
- REQ-007: ra/rb/rc  in  SEL_W each  destination / first source / second source register selects; captured at start.
- REQ-008: mem_addr  out  DATA_W  MAR contents.
- REQ-009: mem_rd  out  1  memory read request, held until acknowledged.
- REQ-010: mem_ack  in  1  read acknowledge; mem_rdata valid in same cycle.
- REQ-011: mem_rdata  in  DATA_W  memory read data.
- REQ-012: busy  out  1  high in every state except IDLE.
- REQ-013: done  out  1  one-cycle pulse after destination register write.
- REQ-014: zero  out  1  high when last written-back value equals 0.
- REQ-015: bus_out  out  DATA_W  current internal bus value (observation).

Function
- REQ-016: Single internal bus, one source per state: R[rb], R[rc], Zlo, MDR or zero; registers Y, Z, MAR, MDR, R[0..NUM_REGS-1].
- REQ-017: FSM states IDLE, T_Y, T_Z, T_MAR, T_RD, T_WB; start in IDLE goes to T_Y (op 0-6) or T_MAR (op 7).
- REQ-018: ALU path: T_Y: bus=R[rb], Y<=bus; T_Z: bus=R[rc], Z<=Y op bus; T_WB: bus=Z, R[ra]<=bus; then IDLE.
- REQ-019: ALU arithmetic modulo 2^DATA_W; SHL/SHR amount = low clog2(DATA_W) bits of R[rc]; NOT ignores R[rc].
- REQ-020: LOAD path: T_MAR: bus=R[rb], MAR<=bus; T_RD: mem_rd=1, stay until mem_ack=1, then MDR<=mem_rdata; T_WB: bus=MDR, R[ra]<=bus.
- REQ-021: mem_rd asserted only in T_RD; no timeout; mem_ack outside T_RD ignored.
- REQ-022: ALU-op latency: done high in the 4th cycle after the cycle start was sampled; LOAD with ack in first T_RD cycle: done in 5th cycle.
- REQ-023: done registered, high exactly one cycle in IDLE following T_WB; zero updated on same edge.
- REQ-024: start while busy ignored, not queued; start and done in same cycle starts a new instruction.
- REQ-025: ra equal to rb or rc allowed; sources read before write-back edge.
- REQ-026: bus_out = 0 in IDLE.

Reset
- REQ-027: Clear low asynchronously forces IDLE, all registers, Y, Z, MAR, MDR to 0, busy/done/mem_rd/zero low (zero output 0), including mid-instruction and while mem_rd pending.
- REQ-028: No register written by an aborted instruction after Clear released.

Configuration
- REQ-029: Macro PARAM_DATAPATH_R0_ZERO_EN defined: R0 reads 0 on bus, writes to R0 discarded, zero updated as if 0 written; undefined: R0 is an ordinary register.

Structure
- REQ-030: Shared package holds op encoding enum, FSM state enum and bus-source select enum.
- REQ-031: ALU is a separate combinational sub-module param_alu (DATA_W parameter, op, a, b -> result).

Verification
- REQ-032: R1=5, R2=7, ADD ra=3 rb=1 rc=2 -> R3=12, done 4th cycle, zero=0.
- REQ-033: R1=3, R2=5, SUB ra=4 -> R4=0xFFFFFFFE; then R1=R2=9 SUB -> zero=1.
- REQ-034: R5=0x100, LOAD ra=6 rb=5, mem_ack after 3 wait cycles with rdata 0xDEADBEEF -> mem_addr=0x100, mem_rd held 4 cycles, R6=0xDEADBEEF.
- REQ-035: start pulsed during T_Z -> ignored, single done; Clear low during T_RD -> mem_rd low immediately, ra unchanged (0), busy low.
- REQ-036: R1=1, R2=33, SHL (DATA_W=32) -> R[ra]=2; with R0_ZERO_EN, ADD ra=0 -> R0 reads 0.
- REQ-037: Rerun REQ-032 with DATA_W=16, NUM_REGS=8 -> identical results modulo 2^16.
